// File: rtl/serial_rx_core_if.sv
// rtl/serial_rx_core_if.sv - byte read port between the RX FIFO head and its consumer
interface serial_rx_core_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_rx_core.sv
// rtl/serial_rx_core.sv - 8N1 UART receiver with mid-bit majority voting and FWFT byte FIFO
module serial_rx_core #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic                               rx,
  serial_rx_core_if.master                   rd,
  output logic                               frame_err,
  output logic                               break_det,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] TAP0 = CW'(MID - 1);
  localparam logic [CW-1:0] TAP1 = CW'(MID);
  localparam logic [CW-1:0] TAP2 = CW'(MID + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          rx_meta;
  logic          rxs;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          t0_q, t0_d;
  logic          t1_q, t1_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;
  logic          brk_q, brk_d;
  logic          maj;
  logic          in_frame;
  logic          resolve;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign maj      = (t0_q & t1_q) | (t0_q & rxs) | (t1_q & rxs);
  assign in_frame = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign resolve  = in_frame && (cnt_q == TAP2);

  // Frame FSM next-state: bit timing, tap capture, majority resolution at the third tap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;

    if (in_frame) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == TAP0) t0_d = rxs;
      if (cnt_q == TAP1) t1_d = rxs;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (resolve) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (resolve) begin
          sh_d = {maj, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is caught on time
        if (resolve) begin
          if (maj) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = (sh_q == 8'h00);
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      t0_q    <= 1'b1;
      t1_q    <= 1'b1;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  // A full FIFO still accepts the byte when the consumer frees a slot on the same edge
  assign full  = (level == FULL_LEVEL);
  assign pop   = rd.valid && rd.ready;
  assign wr_en = push_q && (!full || pop);

  // Byte storage; shift register is stable for the cycle after the stop decision
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= sh_q;
  end

  // FIFO pointers, occupancy and the registered status pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      frame_err <= ferr_q;
      break_det <= brk_q;
      overrun   <= push_q && full && !pop;
    end
  end

  assign rd.valid = (level != '0);
  assign rd.data  = rd.valid ? mem[rd_ptr] : 8'h00;

endmodule
